gvp_store_packer: RTL and testbench

Consumes the store triggers and vector outputs of the GVP execution core and serializes each store event into a tagged AXI-stream packet for the DMA/stream recorder. It sits directly downstream of the GVP core on the same fast clock. It turns the core's held-level `store_data` code into discrete events, snapshots the vector state, buffers snapshots, and emits fixed-length packets under tready back-pressure.

---
 rtl/gvp_pkg.sv | 84 ++++++++
 rtl/gvp_snap_fifo.sv | 50 +++++
 rtl/gvp_store_packer.sv | 196 +++++++++++++++++++
 tb/tb_gvp_store_packer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gvp_pkg.sv
// gvp_pkg: shared constants, record layout and packet word selection for the
// GVP store packer.
//   TAG_BYTE / TYPE_*   : packet tag fields
//   WORDS_*             : packet lengths in 32-bit words
//   snap_rec_t          : 226-bit snapshot record stored in the FIFO
//   rec_last_idx()      : index of the final word for a record type
//   rec_word()          : packet word <idx> of a record
package gvp_pkg;

   localparam logic [7:0] TAG_BYTE  = 8'hA5;
   localparam logic [7:0] TYPE_DATA = 8'h01;
   localparam logic [7:0] TYPE_HDR  = 8'h02;
   localparam logic [7:0] TYPE_END  = 8'h0F;

   localparam logic [2:0] WORDS_DATA = 3'd5;
   localparam logic [2:0] WORDS_HDR  = 3'd7;
   localparam logic [2:0] WORDS_END  = 3'd1;

   typedef enum logic [1:0] {
      REC_NONE = 2'd0,
      REC_DATA = 2'd1,
      REC_HDR  = 2'd2,
      REC_END  = 2'd3
   } rec_type_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } ser_state_t;

   typedef struct packed {
      rec_type_t   rtype;
      logic [15:0] section;
      logic [15:0] seq;
      logic [31:0] options;
      logic [31:0] count;
      logic [31:0] x;
      logic [31:0] y;
      logic [31:0] z;
      logic [31:0] u;
   } snap_rec_t;

   localparam int REC_W = $bits(snap_rec_t);

   function automatic logic [2:0] rec_last_idx(rec_type_t t);
      logic [2:0] last;
      case (t)
         REC_HDR:  last = WORDS_HDR - 3'd1;
         REC_DATA: last = WORDS_DATA - 3'd1;
         default:  last = WORDS_END - 3'd1;
      endcase
      return last;
   endfunction

   function automatic logic [31:0] rec_word(snap_rec_t r, logic [2:0] idx);
      logic [31:0] w;
      w = 32'h0;
      case (r.rtype)
         REC_HDR: begin
            case (idx)
               3'd0:    w = {TAG_BYTE, TYPE_HDR, r.section};
               3'd1:    w = r.options;
               3'd2:    w = r.count;
               3'd3:    w = r.x;
               3'd4:    w = r.y;
               3'd5:    w = r.z;
               default: w = r.u;
            endcase
         end
         REC_DATA: begin
            case (idx)
               3'd0:    w = {TAG_BYTE, TYPE_DATA, r.seq};
               3'd1:    w = r.x;
               3'd2:    w = r.y;
               3'd3:    w = r.z;
               default: w = r.u;
            endcase
         end
         default: w = {TAG_BYTE, TYPE_END, r.seq};
      endcase
      return w;
   endfunction

endpackage

// File: rtl/gvp_snap_fifo.sv
// gvp_snap_fifo: synchronous show-ahead FIFO for snapshot records.
//   a_clk, reset      : clock, async active-high reset (flushes pointers)
//   push, wr_data     : write request; ignored when full unless popping
//   pop, rd_data      : rd_data always shows the head entry; pop advances it
//   full, empty       : occupancy flags
module gvp_snap_fifo #(
   parameter int WIDTH    = 8,
   parameter int DEPTH_N2 = 2
) (
   input  logic             a_clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             pop,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);
   localparam int DEPTH = 1 << DEPTH_N2;
   localparam logic [DEPTH_N2:0] PTR_ONE = 1;

   logic [WIDTH-1:0]  mem [DEPTH];
   logic [DEPTH_N2:0] wr_ptr;
   logic [DEPTH_N2:0] rd_ptr;
   logic              do_push;
   logic              do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[DEPTH_N2] != rd_ptr[DEPTH_N2]) &&
                    (wr_ptr[DEPTH_N2-1:0] == rd_ptr[DEPTH_N2-1:0]);
   assign do_pop  = pop && !empty;
   // a pop in the same cycle frees the slot being written
   assign do_push = push && (!full || do_pop);
   assign rd_data = mem[rd_ptr[DEPTH_N2-1:0]];

   always_ff @(posedge a_clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   always_ff @(posedge a_clk) begin
      if (do_push) mem[wr_ptr[DEPTH_N2-1:0]] <= wr_data;
   end

endmodule

// File: rtl/gvp_store_packer.sv
// gvp_store_packer: turns GVP store codes into tagged AXI-stream packets.
//   a_clk, reset          : clock, async active-high reset
//   enable                : capture enable (draining continues when low)
//   store_data            : 0 none, 1 data point, 2 full header (held level)
//   count, section        : point counter and section count
//   options, x, y, z, u   : section options and vector components
//   gvp_finished          : rising edge queues one end record
//   M_AXIS_*              : packet stream (registered tdata/tvalid/tlast)
//   overflow, drop_count  : sticky drop flag, saturating drop counter
//
// state   | meaning
// IDLE    | no packet on the bus, waiting for a queued record
// SEND    | presenting words of cur_rec, index idx
module gvp_store_packer import gvp_pkg::*; #(
   parameter int DEPTH_N2 = 2
) (
   input  logic        a_clk,
   input  logic        reset,
   input  logic        enable,
   input  logic [1:0]  store_data,
   input  logic [31:0] count,
   input  logic [31:0] section,
   input  logic [31:0] options,
   input  logic [31:0] x,
   input  logic [31:0] y,
   input  logic [31:0] z,
   input  logic [31:0] u,
   input  logic        gvp_finished,
   output logic [31:0] M_AXIS_tdata,
   output logic        M_AXIS_tvalid,
   input  logic        M_AXIS_tready,
   output logic        M_AXIS_tlast,
   output logic        overflow,
   output logic [15:0] drop_count
);
   logic [1:0]  store_data_q;
   logic [31:0] count_q;
   logic [31:0] section_q;
   logic        finished_q;
   logic        evt;
   logic        evt_hdr;
   logic        fin_rise;
   logic        end_pend;
   logic        end_push;
   logic        push;
   logic        drop;
   logic [15:0] seq;

   snap_rec_t   wr_rec;
   snap_rec_t   rd_rec;
   logic [REC_W-1:0] fifo_rd_data;
   logic        fifo_full;
   logic        fifo_empty;
   logic        pop;

   ser_state_t  state, state_nxt;
   snap_rec_t   cur_rec, cur_nxt;
   logic [2:0]  idx, idx_nxt;
   logic [31:0] tdata_nxt;
   logic        tvalid_nxt;
   logic        tlast_nxt;
   logic        load;

   // a held level fires once; only a change in code, count or section re-arms it
   assign evt = enable && (store_data != 2'd0) &&
                ((store_data != store_data_q) || (count != count_q) ||
                 (section != section_q));
   assign evt_hdr  = (store_data == 2'd2);
   assign fin_rise = gvp_finished && !finished_q;
   // the end record waits for a cycle without an event and for FIFO space
   assign end_push = end_pend && !evt && (!fifo_full || pop);
   assign push     = evt || end_push;
   assign drop     = evt && fifo_full && !pop;

   always_comb begin
      wr_rec         = '0;
      wr_rec.section = section[15:0];
      wr_rec.options = options;
      wr_rec.count   = count;
      wr_rec.x       = x;
      wr_rec.y       = y;
      wr_rec.z       = z;
      wr_rec.u       = u;
      if (evt) begin
         wr_rec.rtype = evt_hdr ? REC_HDR : REC_DATA;
         wr_rec.seq   = evt_hdr ? 16'h0 : seq;
      end else begin
         wr_rec.rtype = REC_END;
         wr_rec.seq   = seq;
      end
   end

   gvp_snap_fifo #(
      .WIDTH    (REC_W),
      .DEPTH_N2 (DEPTH_N2)
   ) u_fifo (
      .a_clk   (a_clk),
      .reset   (reset),
      .push    (push),
      .wr_data (wr_rec),
      .pop     (pop),
      .rd_data (fifo_rd_data),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign rd_rec = snap_rec_t'(fifo_rd_data);

   always_ff @(posedge a_clk or posedge reset) begin
      if (reset) begin
         store_data_q <= 2'd0;
         count_q      <= 32'h0;
         section_q    <= 32'h0;
         finished_q   <= 1'b0;
         end_pend     <= 1'b0;
         seq          <= 16'h0;
         overflow     <= 1'b0;
         drop_count   <= 16'h0;
      end else begin
         store_data_q <= store_data;
         count_q      <= count;
         section_q    <= section;
         finished_q   <= gvp_finished;
         if (fin_rise)      end_pend <= 1'b1;
         else if (end_push) end_pend <= 1'b0;
         if (evt) seq <= evt_hdr ? 16'h0 : seq + 16'd1;
         if (drop) begin
            overflow <= 1'b1;
            if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
         end
      end
   end

   always_comb begin
      state_nxt  = state;
      cur_nxt    = cur_rec;
      idx_nxt    = idx;
      tdata_nxt  = M_AXIS_tdata;
      tvalid_nxt = M_AXIS_tvalid;
      tlast_nxt  = M_AXIS_tlast;
      load       = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!fifo_empty) load = 1'b1;
         end
         ST_SEND: begin
            if (M_AXIS_tvalid && M_AXIS_tready) begin
               if (idx == rec_last_idx(cur_rec.rtype)) begin
                  if (!fifo_empty) begin
                     load = 1'b1;
                  end else begin
                     state_nxt  = ST_IDLE;
                     tdata_nxt  = 32'h0;
                     tvalid_nxt = 1'b0;
                     tlast_nxt  = 1'b0;
                  end
               end else begin
                  idx_nxt   = idx + 3'd1;
                  tdata_nxt = rec_word(cur_rec, idx_nxt);
                  tlast_nxt = (idx_nxt == rec_last_idx(cur_rec.rtype));
               end
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
      // back-to-back packets reload straight from the FIFO head
      if (load) begin
         state_nxt  = ST_SEND;
         cur_nxt    = rd_rec;
         idx_nxt    = 3'd0;
         tdata_nxt  = rec_word(rd_rec, 3'd0);
         tvalid_nxt = 1'b1;
         tlast_nxt  = (rec_last_idx(rd_rec.rtype) == 3'd0);
      end
      pop = load;
   end

   always_ff @(posedge a_clk or posedge reset) begin
      if (reset) begin
         state         <= ST_IDLE;
         cur_rec       <= '0;
         idx           <= 3'd0;
         M_AXIS_tdata  <= 32'h0;
         M_AXIS_tvalid <= 1'b0;
         M_AXIS_tlast  <= 1'b0;
      end else begin
         state         <= state_nxt;
         cur_rec       <= cur_nxt;
         idx           <= idx_nxt;
         M_AXIS_tdata  <= tdata_nxt;
         M_AXIS_tvalid <= tvalid_nxt;
         M_AXIS_tlast  <= tlast_nxt;
      end
   end

endmodule

// File: tb/tb_gvp_store_packer.sv
// Directed bench for gvp_store_packer. A negedge monitor records every word
// that will be accepted on the next rising edge; scenario tasks compare the
// recorded stream against hand-computed packets.
module tb_gvp_store_packer;

   logic        a_clk = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b1;
   logic [1:0]  store_data = 2'd0;
   logic [31:0] count = 32'h0;
   logic [31:0] section = 32'h0;
   logic [31:0] options = 32'h0;
   logic [31:0] x = 32'h0;
   logic [31:0] y = 32'h0;
   logic [31:0] z = 32'h0;
   logic [31:0] u = 32'h0;
   logic        gvp_finished = 1'b0;
   logic [31:0] M_AXIS_tdata;
   logic        M_AXIS_tvalid;
   logic        M_AXIS_tready = 1'b1;
   logic        M_AXIS_tlast;
   logic        overflow;
   logic [15:0] drop_count;

   gvp_store_packer #(.DEPTH_N2(2)) dut (
      .a_clk         (a_clk),
      .reset         (reset),
      .enable        (enable),
      .store_data    (store_data),
      .count         (count),
      .section       (section),
      .options       (options),
      .x             (x),
      .y             (y),
      .z             (z),
      .u             (u),
      .gvp_finished  (gvp_finished),
      .M_AXIS_tdata  (M_AXIS_tdata),
      .M_AXIS_tvalid (M_AXIS_tvalid),
      .M_AXIS_tready (M_AXIS_tready),
      .M_AXIS_tlast  (M_AXIS_tlast),
      .overflow      (overflow),
      .drop_count    (drop_count)
   );

   always #4 a_clk = ~a_clk;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   logic [31:0] wq[$];
   logic        lq[$];
   int          cq[$];

   always @(posedge a_clk) cyc++;

   always @(negedge a_clk) begin
      if (!reset && M_AXIS_tvalid && M_AXIS_tready) begin
         wq.push_back(M_AXIS_tdata);
         lq.push_back(M_AXIS_tlast);
         cq.push_back(cyc);
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge a_clk);
         #1;
      end
   endtask

   task automatic clear_q();
      wq.delete();
      lq.delete();
      cq.delete();
   endtask

   task automatic test_reset();
      tick(2);
      tests++; if (M_AXIS_tvalid !== 1'b0) begin fails++; $display("FAIL rst_tvalid: got %b expected 0", M_AXIS_tvalid); end
      tests++; if (M_AXIS_tdata !== 32'h0) begin fails++; $display("FAIL rst_tdata: got %h expected 00000000", M_AXIS_tdata); end
      tests++; if (M_AXIS_tlast !== 1'b0) begin fails++; $display("FAIL rst_tlast: got %b expected 0", M_AXIS_tlast); end
      tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL rst_overflow: got %b expected 0", overflow); end
      tests++; if (drop_count !== 16'h0) begin fails++; $display("FAIL rst_drop_count: got %h expected 0000", drop_count); end
      reset = 1'b0;
      tick(3);
   endtask

   task automatic test_header();
      logic [31:0] e [7];
      e = '{32'hA5020003, 32'h11, 32'h9, 32'h1, 32'h2, 32'h3, 32'h4};
      clear_q();
      section = 32'd3; options = 32'h11; count = 32'd9;
      x = 32'd1; y = 32'd2; z = 32'd3; u = 32'd4;
      store_data = 2'd2;
      @(negedge a_clk);
      tests++; if (M_AXIS_tvalid !== 1'b0) begin fails++; $display("FAIL hdr_lat0_tvalid: got %b expected 0", M_AXIS_tvalid); end
      @(negedge a_clk);
      tests++; if (M_AXIS_tvalid !== 1'b0) begin fails++; $display("FAIL hdr_lat1_tvalid: got %b expected 0", M_AXIS_tvalid); end
      @(negedge a_clk);
      tests++; if (M_AXIS_tvalid !== 1'b1 || M_AXIS_tdata !== 32'hA5020003) begin
         fails++; $display("FAIL hdr_lat2_first: got v=%b d=%h expected v=1 d=a5020003", M_AXIS_tvalid, M_AXIS_tdata);
      end
      tick(12);
      tests++; if (wq.size() != 7) begin fails++; $display("FAIL hdr_len: got %0d expected 7", wq.size()); end
      for (int i = 0; i < 7; i++) begin
         tests++;
         if (i >= wq.size() || wq[i] !== e[i] || lq[i] !== (i == 6)) begin
            fails++; $display("FAIL hdr_word%0d: got %h/%b expected %h/%b", i, (i < wq.size()) ? wq[i] : 32'hx, (i < lq.size()) ? lq[i] : 1'bx, e[i], (i == 6));
         end
      end
   endtask

   task automatic test_data_stream();
      logic [31:0] e [15];
      x = 32'hFFFF_FFF0; y = 32'h7FFF_0000; z = 32'h0000_0100; u = 32'h8000_0001;
      e = '{32'hA5010000, 32'hFFFFFFF0, 32'h7FFF0000, 32'h00000100, 32'h80000001,
            32'hA5010001, 32'hFFFFFFF0, 32'h7FFF0000, 32'h00000100, 32'h80000001,
            32'hA5010002, 32'hFFFFFFF0, 32'h7FFF0000, 32'h00000100, 32'h80000001};
      clear_q();
      store_data = 2'd1; count = 32'd5;
      tick(1); count = 32'd4;
      tick(1); count = 32'd3;
      tick(25);
      tests++; if (wq.size() != 15) begin fails++; $display("FAIL data_len: got %0d expected 15", wq.size()); end
      for (int i = 0; i < 15; i++) begin
         tests++;
         if (i >= wq.size() || wq[i] !== e[i] || lq[i] !== ((i % 5) == 4)) begin
            fails++; $display("FAIL data_word%0d: got %h/%b expected %h/%b", i, (i < wq.size()) ? wq[i] : 32'hx, (i < lq.size()) ? lq[i] : 1'bx, e[i], ((i % 5) == 4));
         end
      end
      clear_q();
      enable = 1'b0; count = 32'd99;
      tick(1); count = 32'd98;
      tick(1); enable = 1'b1;
      tick(10);
      tests++; if (wq.size() != 0) begin fails++; $display("FAIL data_disabled_len: got %0d expected 0", wq.size()); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] e [10];
      bit got;
      e = '{32'hA5010003, 32'hFFFFFFF0, 32'h7FFF0000, 32'h00000100, 32'h80000001,
            32'hA5010004, 32'hFFFFFFF0, 32'h7FFF0000, 32'h00000100, 32'h80000001};
      clear_q();
      count = 32'd2;
      tick(1); count = 32'd1;
      got = 1'b0;
      for (int t = 0; t < 20 && !got; t++) begin
         tick(1);
         if (wq.size() >= 2) got = 1'b1;
      end
      tests++; if (!got) begin fails++; $display("FAIL bp_wait: got %0d words expected 2 within budget", wq.size()); end
      M_AXIS_tready = 1'b0;
      for (int t = 0; t < 10; t++) begin
         @(negedge a_clk);
         tests++;
         if (M_AXIS_tvalid !== 1'b1 || M_AXIS_tdata !== 32'h7FFF0000 || M_AXIS_tlast !== 1'b0) begin
            fails++; $display("FAIL bp_stall%0d: got v=%b d=%h l=%b expected v=1 d=7fff0000 l=0", t, M_AXIS_tvalid, M_AXIS_tdata, M_AXIS_tlast);
         end
      end
      @(posedge a_clk); #1;
      M_AXIS_tready = 1'b1;
      tick(20);
      tests++; if (wq.size() != 10) begin fails++; $display("FAIL bp_len: got %0d expected 10", wq.size()); end
      for (int i = 0; i < 10; i++) begin
         tests++;
         if (i >= wq.size() || wq[i] !== e[i] || lq[i] !== ((i % 5) == 4)) begin
            fails++; $display("FAIL bp_word%0d: got %h/%b expected %h/%b", i, (i < wq.size()) ? wq[i] : 32'hx, (i < lq.size()) ? lq[i] : 1'bx, e[i], ((i % 5) == 4));
         end
      end
      tests++;
      if (cq.size() < 6 || cq[5] != cq[4] + 1) begin
         fails++; $display("FAIL bp_no_bubble: got gap %0d expected 1", (cq.size() >= 6) ? cq[5] - cq[4] : -1);
      end
   endtask

   task automatic test_overflow();
      clear_q();
      M_AXIS_tready = 1'b0;
      tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL ovf_pre: got %b expected 0", overflow); end
      store_data = 2'd2; count = 32'd50;
      tick(3);
      for (int k = 0; k < 6; k++) begin
         store_data = 2'd1; count = 32'd60 + k;
         tick(1);
      end
      tick(2);
      tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
      tests++; if (drop_count !== 16'd2) begin fails++; $display("FAIL ovf_drop_count: got %0d expected 2", drop_count); end
      M_AXIS_tready = 1'b1;
      tick(45);
      tests++; if (wq.size() != 27) begin fails++; $display("FAIL ovf_len: got %0d expected 27", wq.size()); end
      tests++; if (wq.size() < 1 || wq[0] !== 32'hA5020003) begin fails++; $display("FAIL ovf_hdr_tag: got %h expected a5020003", (wq.size() > 0) ? wq[0] : 32'hx); end
      for (int p = 0; p < 4; p++) begin
         tests++;
         if (wq.size() <= 7 + 5 * p || wq[7 + 5 * p] !== (32'hA5010000 + p)) begin
            fails++; $display("FAIL ovf_data_tag%0d: got %h expected %h", p, (wq.size() > 7 + 5 * p) ? wq[7 + 5 * p] : 32'hx, 32'hA5010000 + p);
         end
      end
      tests++; if (drop_count !== 16'd2) begin fails++; $display("FAIL ovf_drop_hold: got %0d expected 2", drop_count); end
   endtask

   task automatic test_finish();
      logic [31:0] e [8];
      e = '{32'hA5020003, 32'h11, 32'd200, 32'hFFFFFFF0, 32'h7FFF0000, 32'h00000100, 32'h80000001, 32'hA50F0000};
      clear_q();
      store_data = 2'd2; count = 32'd200; gvp_finished = 1'b1;
      tick(25);
      tests++; if (wq.size() != 8) begin fails++; $display("FAIL fin_len: got %0d expected 8", wq.size()); end
      for (int i = 0; i < 8; i++) begin
         tests++;
         if (i >= wq.size() || wq[i] !== e[i] || lq[i] !== (i >= 6)) begin
            fails++; $display("FAIL fin_word%0d: got %h/%b expected %h/%b", i, (i < wq.size()) ? wq[i] : 32'hx, (i < lq.size()) ? lq[i] : 1'bx, e[i], (i >= 6));
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] e [5];
      bit got;
      e = '{32'hA5010000, 32'hFFFFFFF0, 32'h7FFF0000, 32'h00000100, 32'h80000001};
      clear_q();
      section = 32'd4;
      got = 1'b0;
      for (int t = 0; t < 20 && !got; t++) begin
         tick(1);
         if (wq.size() >= 2) got = 1'b1;
      end
      tests++; if (!got) begin fails++; $display("FAIL rmid_wait: got %0d words expected 2 within budget", wq.size()); end
      reset = 1'b1;
      store_data = 2'd0; gvp_finished = 1'b0;
      #1;
      tests++; if (M_AXIS_tvalid !== 1'b0 || M_AXIS_tdata !== 32'h0 || M_AXIS_tlast !== 1'b0) begin
         fails++; $display("FAIL rmid_outputs: got v=%b d=%h l=%b expected 0/0/0", M_AXIS_tvalid, M_AXIS_tdata, M_AXIS_tlast);
      end
      tests++; if (overflow !== 1'b0 || drop_count !== 16'h0) begin
         fails++; $display("FAIL rmid_ovf: got %b/%0d expected 0/0", overflow, drop_count);
      end
      tick(2);
      reset = 1'b0;
      tick(4);
      tests++; if (wq.size() != 2) begin fails++; $display("FAIL rmid_abort_len: got %0d expected 2", wq.size()); end
      clear_q();
      store_data = 2'd1; count = 32'd300;
      tick(15);
      tests++; if (wq.size() != 5) begin fails++; $display("FAIL rmid_len: got %0d expected 5", wq.size()); end
      for (int i = 0; i < 5; i++) begin
         tests++;
         if (i >= wq.size() || wq[i] !== e[i] || lq[i] !== (i == 4)) begin
            fails++; $display("FAIL rmid_word%0d: got %h/%b expected %h/%b", i, (i < wq.size()) ? wq[i] : 32'hx, (i < lq.size()) ? lq[i] : 1'bx, e[i], (i == 4));
         end
      end
   endtask

   initial begin
      test_reset();
      test_header();
      test_data_stream();
      test_back_to_back();
      test_overflow();
      test_finish();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
